mux_n: RTL and testbench



---
 rtl/mux_pkg.sv | 7 +
 rtl/mux_n_reg.sv | 14 +
 rtl/mux_n.sv | 31 +++
 tb/tb_mux_n.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and index helper for the MSB-first mux
package mux_pkg;
    localparam int MUX_N_DEFAULT = 8;
    function automatic int rev_index(input int k, input int n);
        return n - 1 - k;
    endfunction
endpackage

// File: rtl/mux_n_reg.sv
// mux_n_reg: output register pair with synchronous active-high reset
module mux_n_reg (
    input  logic clk,
    input  logic reset,
    input  logic y,
    input  logic sel_err,
    output logic y_q,
    output logic sel_err_q
);
    always_ff @(posedge clk) begin
        y_q       <= reset ? 1'b0 : y;
        sel_err_q <= reset ? 1'b0 : sel_err;
    end
endmodule

// File: rtl/mux_n.sv
// mux_n: N-to-1 single-bit mux, MSB-first select, with registered copy and range flag
module mux_n
    import mux_pkg::*;
#(
    parameter int N     = MUX_N_DEFAULT,
    parameter int SEL_W = $clog2(N)
) (
    output logic             y,
    input  logic [N-1:0]     x,
    input  logic [SEL_W-1:0] ss,
    input  logic             clk,
    input  logic             reset,
    output logic             y_q,
    output logic             sel_err,
    output logic             sel_err_q
);
    // an out-of-range select forces y low instead of indexing past the bus
    always_comb begin
        sel_err = int'(ss) >= N;
        y       = sel_err ? 1'b0 : x[SEL_W'(rev_index(int'(ss), N))];
    end

    mux_n_reg u_reg (
        .clk      (clk),
        .reset    (reset),
        .y        (y),
        .sel_err  (sel_err),
        .y_q      (y_q),
        .sel_err_q(sel_err_q)
    );
endmodule

// File: tb/tb_mux_n.sv
// tb_mux_n: self-checking bench for mux_n at N=8 and N=5
module tb_mux_n;
    int passed = 0;
    int total  = 0;
    logic clk = 1'b0;
    logic reset;
    logic [7:0] x8;
    logic [2:0] ss8;
    logic y8, yq8, e8, eq8;
    logic [4:0] x5;
    logic [2:0] ss5;
    logic y5, yq5, e5, eq5;

    always #5 clk = ~clk;

    mux_n #(.N(8)) d8 (
        .y(y8), .x(x8), .ss(ss8), .clk(clk), .reset(reset),
        .y_q(yq8), .sel_err(e8), .sel_err_q(eq8)
    );
    mux_n #(.N(5)) d5 (
        .y(y5), .x(x5), .ss(ss5), .clk(clk), .reset(reset),
        .y_q(yq5), .sel_err(e5), .sel_err_q(eq5)
    );

    // bit at position n-1-ss of x, by shifting; zero when ss is past the bus
    function automatic logic model_y(input logic [7:0] x, input int ss, input int n);
        return ss < n && ((x >> (n - 1 - ss)) & 8'd1) != 8'd0;
    endfunction

    task automatic test_reset;
        reset = 1'b1; x8 = 8'hff; ss8 = 3'd0; x5 = 5'h1f; ss5 = 3'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (yq8 !== 1'b0) $display("FAIL reset_yq8 got %b want 0", yq8); else passed++;
        total++; if (eq8 !== 1'b0) $display("FAIL reset_eq8 got %b want 0", eq8); else passed++;
        total++; if (eq5 !== 1'b0) $display("FAIL reset_eq5 got %b want 0", eq5); else passed++;
        total++; if (y8 !== 1'b1) $display("FAIL reset_y8_comb got %b want 1", y8); else passed++;
    endtask

    task automatic test_exhaustive;
        logic exp_y [8] = '{1, 0, 1, 0, 1, 1, 0, 0};
        x8 = 8'b10101100;
        for (int k = 0; k < 8; k++) begin
            ss8 = 3'(k);
            #1;
            total++; if (y8 !== exp_y[k]) $display("FAIL exh_y ss=%0d got %b want %b", k, y8, exp_y[k]); else passed++;
            total++; if (e8 !== 1'b0) $display("FAIL exh_err ss=%0d got %b want 0", k, e8); else passed++;
        end
    endtask

    task automatic test_direction;
        for (int k = 0; k < 8; k++) begin
            x8 = 8'b00000001; ss8 = 3'(k);
            #1;
            total++; if (y8 !== (k == 7)) $display("FAIL dir_lsb ss=%0d got %b want %b", k, y8, k == 7); else passed++;
            x8 = 8'b10000000;
            #1;
            total++; if (y8 !== (k == 0)) $display("FAIL dir_msb ss=%0d got %b want %b", k, y8, k == 0); else passed++;
        end
    endtask

    task automatic test_registered;
        logic exp_y [8] = '{1, 0, 1, 0, 1, 1, 0, 0};
        reset = 1'b0; x8 = 8'b10101100;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k > 0) begin
                total++; if (yq8 !== exp_y[k-1]) $display("FAIL reg_yq step=%0d got %b want %b", k - 1, yq8, exp_y[k-1]); else passed++;
            end
            if (k < 8) ss8 = 3'(k);
        end
    endtask

    task automatic test_sync_reset;
        @(negedge clk);
        x8 = 8'b10101100; ss8 = 3'd0; reset = 1'b1;
        @(negedge clk);
        total++; if (yq8 !== 1'b0) $display("FAIL srst_yq got %b want 0", yq8); else passed++;
        total++; if (eq8 !== 1'b0) $display("FAIL srst_eq got %b want 0", eq8); else passed++;
        total++; if (y8 !== 1'b1) $display("FAIL srst_y_comb got %b want 1", y8); else passed++;
        @(negedge clk);
        reset = 1'b0;
        total++; if (yq8 !== 1'b0) $display("FAIL srst_hold got %b want 0", yq8); else passed++;
        @(negedge clk);
        total++; if (yq8 !== 1'b1) $display("FAIL srst_release got %b want 1", yq8); else passed++;
    endtask

    task automatic test_offedge_reset;
        @(negedge clk);
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        total++; if (yq8 !== 1'b1) $display("FAIL offedge_pre got %b want 1", yq8); else passed++;
        @(negedge clk);
        total++; if (yq8 !== 1'b1) $display("FAIL offedge_post got %b want 1", yq8); else passed++;
    endtask

    task automatic test_non_pow2;
        logic exp_y [8] = '{1, 0, 1, 1, 0, 0, 0, 0};
        x5 = 5'b10110;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            ss5 = 3'(k);
            #1;
            total++; if (y5 !== exp_y[k]) $display("FAIL np2_y ss=%0d got %b want %b", k, y5, exp_y[k]); else passed++;
            total++; if (e5 !== (k >= 5)) $display("FAIL np2_err ss=%0d got %b want %b", k, e5, k >= 5); else passed++;
            @(negedge clk);
            total++; if (eq5 !== (k >= 5)) $display("FAIL np2_err_q ss=%0d got %b want %b", k, eq5, k >= 5); else passed++;
            total++; if (yq5 !== exp_y[k]) $display("FAIL np2_yq ss=%0d got %b want %b", k, yq5, exp_y[k]); else passed++;
        end
    endtask

    task automatic test_random;
        logic p8, p5, pe5;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i > 0) begin
                total++; if (yq8 !== p8) $display("FAIL rnd_yq8 i=%0d got %b want %b", i, yq8, p8); else passed++;
                total++; if (yq5 !== p5) $display("FAIL rnd_yq5 i=%0d got %b want %b", i, yq5, p5); else passed++;
                total++; if (eq5 !== pe5) $display("FAIL rnd_eq5 i=%0d got %b want %b", i, eq5, pe5); else passed++;
            end
            x8 = 8'($urandom); ss8 = 3'($urandom);
            x5 = 5'($urandom); ss5 = 3'($urandom);
            #1;
            p8  = model_y(x8, int'(ss8), 8);
            p5  = model_y({3'b000, x5}, int'(ss5), 5);
            pe5 = int'(ss5) >= 5;
            total++; if (y8 !== p8) $display("FAIL rnd_y8 x=%h ss=%0d got %b want %b", x8, ss8, y8, p8); else passed++;
            total++; if (y5 !== p5) $display("FAIL rnd_y5 x=%h ss=%0d got %b want %b", x5, ss5, y5, p5); else passed++;
            total++; if (e5 !== pe5) $display("FAIL rnd_e5 ss=%0d got %b want %b", ss5, e5, pe5); else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_exhaustive;
        test_direction;
        test_registered;
        test_sync_reset;
        test_offedge_reset;
        test_non_pow2;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end
endmodule
